// File: rtl/bram_dual_port_arbiter.sv
// bram_dual_port_arbiter: shares one byte-mode 1 KB block RAM between requesters A and B.
// Rev 1.0 - independent read/write port arbitration with fixed-latency read return.
`default_nettype none

module bram_dual_port_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [9:0]  a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_rsp_valid,
  output logic [7:0]  a_rsp_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_we,
  input  logic [9:0]  b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_rsp_valid,
  output logic [7:0]  b_rsp_data,
  output logic [7:0]  bram_rd_addr,
  output logic [7:0]  bram_wr_addr,
  output logic [31:0] bram_wr_data,
  input  logic [31:0] bram_rd_data,
  output logic [5:0]  bram_c
);

  localparam int LAT = (RD_LATENCY == 2) ? 2 : 1;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e wr_ptr;
  req_e rd_ptr;
  req_e wr_sel;
  req_e rd_sel;

  logic       a_rd, a_wr, b_rd, b_wr;
  logic       wr_grant, rd_req, rd_grant, collision;
  logic [9:0] wr_addr_sel, rd_addr_sel;
  logic [7:0] wr_data_sel;

  logic [LAT-1:0] pipe_v;
  logic [LAT-1:0] pipe_b;

  logic unused_rd_hi;
  assign unused_rd_hi = ^bram_rd_data[31:8];

  // C5 enables the RAM output register only for the two-cycle read path.
  assign bram_c = {((LAT == 2) ? 1'b1 : 1'b0), 5'b00101};

  always_comb begin
    // Gating with resetn keeps ready and RAM controls quiet while reset is held.
    a_rd = a_valid && !a_we && resetn;
    a_wr = a_valid &&  a_we && resetn;
    b_rd = b_valid && !b_we && resetn;
    b_wr = b_valid &&  b_we && resetn;

    wr_grant = a_wr || b_wr;
    rd_req   = a_rd || b_rd;

    if (a_wr && b_wr) begin
      wr_sel = wr_ptr;
    end else if (b_wr) begin
      wr_sel = REQ_B;
    end else begin
      wr_sel = REQ_A;
    end

    if (a_rd && b_rd) begin
      rd_sel = rd_ptr;
    end else if (b_rd) begin
      rd_sel = REQ_B;
    end else begin
      rd_sel = REQ_A;
    end

    wr_addr_sel = (wr_sel == REQ_B) ? b_addr  : a_addr;
    wr_data_sel = (wr_sel == REQ_B) ? b_wdata : a_wdata;
    rd_addr_sel = (rd_sel == REQ_B) ? b_addr  : a_addr;

    // A same-word read alongside a write is deferred so the write always lands.
    collision = wr_grant && rd_req && (wr_addr_sel[9:2] == rd_addr_sel[9:2]);
    rd_grant  = rd_req && !collision;

    a_ready = (wr_grant && (wr_sel == REQ_A)) || (rd_grant && (rd_sel == REQ_A));
    b_ready = (wr_grant && (wr_sel == REQ_B)) || (rd_grant && (rd_sel == REQ_B));

    bram_wr_addr = 8'h00;
    bram_rd_addr = 8'h00;
    bram_wr_data = 32'h0000_0000;
    if (wr_grant) begin
      bram_wr_addr        = wr_addr_sel[9:2];
      bram_wr_data[7:0]   = wr_data_sel;
      bram_wr_data[17:16] = wr_addr_sel[1:0];
      bram_wr_data[20]    = 1'b1;
    end
    if (rd_grant) begin
      bram_rd_addr        = rd_addr_sel[9:2];
      bram_wr_data[25:24] = rd_addr_sel[1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= REQ_A;
      rd_ptr <= REQ_A;
    end else begin
      if (wr_grant) begin
        wr_ptr <= (wr_sel == REQ_A) ? REQ_B : REQ_A;
      end
      if (rd_grant) begin
        rd_ptr <= (rd_sel == REQ_A) ? REQ_B : REQ_A;
      end
    end
  end

  // Tag pipeline mirrors the RAM read latency so data and requester line up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      pipe_b <= '0;
    end else begin
      pipe_v[0] <= rd_grant;
      pipe_b[0] <= (rd_sel == REQ_B);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_b[i] <= pipe_b[i-1];
      end
    end
  end

  always_comb begin
    a_rsp_valid = pipe_v[LAT-1] && !pipe_b[LAT-1];
    b_rsp_valid = pipe_v[LAT-1] &&  pipe_b[LAT-1];
    a_rsp_data  = a_rsp_valid ? bram_rd_data[7:0] : 8'h00;
    b_rsp_data  = b_rsp_valid ? bram_rd_data[7:0] : 8'h00;
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_dual_port_arbiter.sv
// tb_bram_dual_port_arbiter: drives identical traffic into latency-1 and latency-2 instances.
// Rev 1.0
`default_nettype none

module tb_bram_dual_port_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic a_valid, a_we, b_valid, b_we;
  logic [9:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic a_ready1, b_ready1, a_rsp_valid1, b_rsp_valid1;
  logic [7:0] a_rsp_data1, b_rsp_data1, bram_rd_addr1, bram_wr_addr1;
  logic [31:0] bram_wr_data1, bram_rd_data1;
  logic [5:0] bram_c1;

  logic a_ready2, b_ready2, a_rsp_valid2, b_rsp_valid2;
  logic [7:0] a_rsp_data2, b_rsp_data2, bram_rd_addr2, bram_wr_addr2;
  logic [31:0] bram_wr_data2, bram_rd_data2;
  logic [5:0] bram_c2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_dual_port_arbiter #(.RD_LATENCY(1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_ready(a_ready1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid1), .a_rsp_data(a_rsp_data1),
    .b_valid(b_valid), .b_ready(b_ready1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid1), .b_rsp_data(b_rsp_data1),
    .bram_rd_addr(bram_rd_addr1), .bram_wr_addr(bram_wr_addr1), .bram_wr_data(bram_wr_data1),
    .bram_rd_data(bram_rd_data1), .bram_c(bram_c1)
  );

  bram_dual_port_arbiter #(.RD_LATENCY(2)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_ready(a_ready2), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid2), .a_rsp_data(a_rsp_data2),
    .b_valid(b_valid), .b_ready(b_ready2), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid2), .b_rsp_data(b_rsp_data2),
    .bram_rd_addr(bram_rd_addr2), .bram_wr_addr(bram_wr_addr2), .bram_wr_data(bram_wr_data2),
    .bram_rd_data(bram_rd_data2), .bram_c(bram_c2)
  );

  // Byte-mode RAM models: lane for writes in [17:16], for reads in [25:24], write enable bit 20.
  logic [7:0] mem1 [1024];
  logic [7:0] mem2 [1024];
  logic [7:0] ram1_q, ram2_q, ram2_qq;

  always @(posedge clk) begin
    ram1_q <= mem1[{bram_rd_addr1, bram_wr_data1[25:24]}];
    if (bram_wr_data1[20]) mem1[{bram_wr_addr1, bram_wr_data1[17:16]}] <= bram_wr_data1[7:0];
    ram2_q  <= mem2[{bram_rd_addr2, bram_wr_data2[25:24]}];
    ram2_qq <= ram2_q;
    if (bram_wr_data2[20]) mem2[{bram_wr_addr2, bram_wr_data2[17:16]}] <= bram_wr_data2[7:0];
  end

  assign bram_rd_data1 = {24'h0, ram1_q};
  assign bram_rd_data2 = {24'h0, ram2_qq};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected responses keyed by the cycle in which they must appear.
  typedef struct packed {
    int         due;
    logic       b;
    logic [7:0] d;
  } sb_t;

  sb_t sq1[$];
  sb_t sq2[$];
  sb_t ent;
  logic [7:0] ref_mem [1024];
  logic [17:0] e1, e2;

  always @(negedge clk) begin
    if (!resetn) begin
      sq1.delete();
      sq2.delete();
    end
    e1 = '0;
    while (sq1.size() > 0 && sq1[0].due < cyc) sq1.delete(0);
    if (sq1.size() > 0 && sq1[0].due == cyc) begin
      ent = sq1.pop_front();
      if (ent.b) e1[8:0] = {1'b1, ent.d}; else e1[17:9] = {1'b1, ent.d};
    end
    chk("rsp_lat1", {a_rsp_valid1, a_rsp_data1, b_rsp_valid1, b_rsp_data1}, e1);
    e2 = '0;
    while (sq2.size() > 0 && sq2[0].due < cyc) sq2.delete(0);
    if (sq2.size() > 0 && sq2[0].due == cyc) begin
      ent = sq2.pop_front();
      if (ent.b) e2[8:0] = {1'b1, ent.d}; else e2[17:9] = {1'b1, ent.d};
    end
    chk("rsp_lat2", {a_rsp_valid2, a_rsp_data2, b_rsp_valid2, b_rsp_data2}, e2);
    if (resetn) begin
      if (a_valid && a_ready1 && !a_we) begin
        sq1.push_back(sb_t'{due: cyc + 1, b: 1'b0, d: ref_mem[a_addr]});
        sq2.push_back(sb_t'{due: cyc + 2, b: 1'b0, d: ref_mem[a_addr]});
      end
      if (b_valid && b_ready1 && !b_we) begin
        sq1.push_back(sb_t'{due: cyc + 1, b: 1'b1, d: ref_mem[b_addr]});
        sq2.push_back(sb_t'{due: cyc + 2, b: 1'b1, d: ref_mem[b_addr]});
      end
      if (a_valid && a_ready1 && a_we) ref_mem[a_addr] = a_wdata;
      if (b_valid && b_ready1 && b_we) ref_mem[b_addr] = b_wdata;
    end
  end

  function automatic logic [67:0] outs1();
    return {a_ready1, b_ready1, a_rsp_valid1, a_rsp_data1, b_rsp_valid1, b_rsp_data1,
            bram_rd_addr1, bram_wr_addr1, bram_wr_data1};
  endfunction

  function automatic logic [67:0] outs2();
    return {a_ready2, b_ready2, a_rsp_valid2, a_rsp_data2, b_rsp_valid2, b_rsp_data2,
            bram_rd_addr2, bram_wr_addr2, bram_wr_data2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic we, input logic [9:0] ad, input logic [7:0] d);
    a_valid = v; a_we = we; a_addr = ad; a_wdata = d;
  endtask

  task automatic drv_b(input logic v, input logic we, input logic [9:0] ad, input logic [7:0] d);
    b_valid = v; b_we = we; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    drv_a(1'b0, 1'b0, 10'h0, 8'h0);
    drv_b(1'b0, 1'b0, 10'h0, 8'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = 8'h00; mem2[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    resetn = 1'b0;
    idle();
    repeat (2) tick();
    #1;
    chk("rst_outs1", outs1(), 68'h0);
    chk("rst_outs2", outs2(), 68'h0);
    chk("bram_c_lat1", bram_c1, 6'b000101);
    chk("bram_c_lat2", bram_c2, 6'b100101);
    resetn = 1'b1;
    tick();

    // Write contention: both write every cycle, grants alternate starting at A.
    drv_a(1'b1, 1'b1, 10'h100, 8'h11);
    drv_b(1'b1, 1'b1, 10'h104, 8'h22);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_contend_rdy", {a_ready1, b_ready1, a_ready2, b_ready2}, (i % 2 == 0) ? 4'b1010 : 4'b0101);
      chk("wr_contend_addr", bram_wr_addr1, (i % 2 == 0) ? 8'h40 : 8'h41);
      tick();
    end
    idle();

    // Basic write then read of the top byte.
    drv_a(1'b1, 1'b1, 10'h3FE, 8'hA5);
    #1;
    chk("wr_basic_rdy", {a_ready1, a_ready2}, 2'b11);
    chk("wr_basic_addr", {bram_wr_addr1, bram_wr_addr2}, 16'hFFFF);
    chk("wr_basic_data", bram_wr_data1, 32'h0012_00A5);
    tick();
    idle();
    drv_b(1'b1, 1'b0, 10'h3FE, 8'h00);
    #1;
    chk("rd_basic_rdy", {b_ready1, b_ready2}, 2'b11);
    chk("rd_basic_addr", bram_rd_addr1, 8'hFF);
    chk("rd_basic_ctl", bram_wr_data1, 32'h0200_0000);
    tick();
    idle();
    #1;
    chk("rd_basic_rsp1", {b_rsp_valid1, b_rsp_data1, b_rsp_valid2}, {1'b1, 8'hA5, 1'b0});
    tick();
    #1;
    chk("rd_basic_rsp2", {b_rsp_valid2, b_rsp_data2, b_rsp_valid1}, {1'b1, 8'hA5, 1'b0});

    // Read on one port and write on the other in the same cycle.
    drv_a(1'b1, 1'b0, 10'h010, 8'h00);
    drv_b(1'b1, 1'b1, 10'h020, 8'h3C);
    #1;
    chk("par_rdy", {a_ready1, b_ready1, a_ready2, b_ready2}, 4'b1111);
    chk("par_addr", {bram_rd_addr1, bram_wr_addr1}, 16'h0408);
    chk("par_data", bram_wr_data1, 32'h0010_003C);
    tick();
    idle();
    #1;
    chk("par_rsp", {a_rsp_valid1, a_rsp_data1}, {1'b1, 8'h00});
    tick();

    // Same-word collision: write goes first, read follows next cycle.
    drv_a(1'b1, 1'b0, 10'h011, 8'h00);
    drv_b(1'b1, 1'b1, 10'h013, 8'h55);
    #1;
    chk("coll_rdy1", {a_ready1, b_ready1, a_ready2, b_ready2}, 4'b0101);
    chk("coll_addr1", {bram_rd_addr1, bram_wr_addr1}, 16'h0004);
    chk("coll_data1", bram_wr_data1, 32'h0013_0055);
    tick();
    drv_b(1'b0, 1'b0, 10'h0, 8'h00);
    #1;
    chk("coll_rdy2", {a_ready1, b_ready1, a_ready2, b_ready2}, 4'b1010);
    chk("coll_addr2", bram_rd_addr1, 8'h04);
    chk("coll_data2", bram_wr_data1, 32'h0100_0000);
    tick();
    idle();
    #1;
    chk("coll_rsp", {a_rsp_valid1, a_rsp_data1}, {1'b1, 8'h00});
    tick();

    // Read contention: last granted read was A, so B wins first.
    drv_a(1'b1, 1'b0, 10'h3FE, 8'h00);
    drv_b(1'b1, 1'b0, 10'h013, 8'h00);
    #1;
    chk("rd_contend1", {a_ready1, b_ready1, a_ready2, b_ready2}, 4'b0101);
    tick();
    drv_b(1'b0, 1'b0, 10'h0, 8'h00);
    #1;
    chk("rd_lane3_rsp", {b_rsp_valid1, b_rsp_data1}, {1'b1, 8'h55});
    chk("rd_contend2", {a_ready1, b_ready1, a_ready2, b_ready2}, 4'b1010);
    tick();
    idle();
    #1;
    chk("rd_contend_rsp", {a_rsp_valid1, a_rsp_data1}, {1'b1, 8'hA5});
    tick();

    // Back-to-back reads: latency-2 responses trail by one cycle, in order.
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b1, 1'b1, 10'(i), 8'(16 * (i + 1)));
      #1;
      chk("seq_wr_rdy", a_ready1, 1'b1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv_a(1'b1, 1'b0, 10'(i), 8'h00);
      #1;
      chk("seq_rd_rdy", {a_ready1, a_ready2}, 2'b11);
      tick();
      #1;
      chk("seq_lat1_rsp", {a_rsp_valid1, a_rsp_data1}, {1'b1, 8'(16 * (i + 1))});
      if (i > 0) chk("seq_lat2_rsp", {a_rsp_valid2, a_rsp_data2}, {1'b1, 8'(16 * i)});
      else       chk("seq_lat2_wait", a_rsp_valid2, 1'b0);
    end
    idle();
    tick();
    #1;
    chk("seq_lat2_last", {a_rsp_valid2, a_rsp_data2, a_rsp_valid1}, {1'b1, 8'h30, 1'b0});
    tick();

    // Reset one cycle after a read handshake: latency-2 response must never appear.
    drv_a(1'b1, 1'b0, 10'h3FE, 8'h00);
    tick();
    idle();
    chk("rst_pre", {a_rsp_valid1, a_rsp_data1, a_rsp_valid2}, {1'b1, 8'hA5, 1'b0});
    resetn = 1'b0;
    drv_a(1'b1, 1'b0, 10'h001, 8'h00);
    #1;
    chk("rst_mid_outs1", outs1(), 68'h0);
    chk("rst_mid_outs2", outs2(), 68'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("rst_hold_outs1", outs1(), 68'h0);
      chk("rst_hold_outs2", outs2(), 68'h0);
    end
    idle();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_after_outs1", outs1(), 68'h0);
      chk("rst_after_outs2", outs2(), 68'h0);
    end
    chk("sb_empty", sq1.size() + sq2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
